// File: rtl/alu_issue.sv
// Single-issue ALU sequencer: decodes ALUOp/funct, drives an external ALU for one cycle, and holds the result until it is consumed.
// Optional feature: define BRANCH_RESOLVE_EN to resolve beq-style branches (sub with zero result) into out_branch.
module alu_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  alu_op,
    input  logic [5:0]  funct,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_sel,
    input  logic [31:0] alu_res,
    input  logic        alu_zf,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_res,
    output logic        out_zf,
    output logic        out_err,
    output logic        out_branch
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

    localparam logic [2:0] SEL_ADD = 3'b000;
    localparam logic [2:0] SEL_SUB = 3'b001;
    localparam logic [2:0] SEL_OR  = 3'b010;
    localparam logic [2:0] SEL_AND = 3'b011;
    localparam logic [2:0] SEL_SLT = 3'b100;

    state_e      state_q, state_d;
    logic [31:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [2:0]  alu_sel_q, alu_sel_d;
    logic        err_q, err_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_res_q, out_res_d;
    logic        out_zf_q, out_zf_d;
    logic        out_err_q, out_err_d;
    logic        accept, capture, release_res;
    logic [2:0]  dec_sel;
    logic        dec_err;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = EXEC;
            EXEC:    state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready    = (state_q == IDLE) && !rst;
        accept      = (state_q == IDLE) && in_valid;
        capture     = (state_q == EXEC);
        release_res = (state_q == DONE) && out_ready;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        dec_sel = SEL_ADD;
        dec_err = 1'b0;
        case (alu_op)
            2'b00: dec_sel = SEL_ADD;
            2'b01: dec_sel = SEL_SUB;
            2'b11: dec_sel = SEL_OR;
            default: begin
                case (funct)
                    6'b100000: dec_sel = SEL_ADD;
                    6'b100010: dec_sel = SEL_SUB;
                    6'b100100: dec_sel = SEL_AND;
                    6'b100101: dec_sel = SEL_OR;
                    6'b101010: dec_sel = SEL_SLT;
                    default:   dec_err = 1'b1;
                endcase
            end
        endcase
    end

    always_comb begin
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        out_res_d   = out_res_q;
        out_zf_d    = out_zf_q;
        out_err_d   = out_err_q;
        if (accept) begin
            alu_a_d   = op_a;
            alu_b_d   = op_b;
            alu_sel_d = dec_sel;
            err_d     = dec_err;
        end
        if (capture) begin
            out_valid_d = 1'b1;
            out_res_d   = err_q ? 32'd0 : alu_res;
            out_zf_d    = err_q ? 1'b0 : alu_zf;
            out_err_d   = err_q;
        end
        if (release_res) out_valid_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= SEL_ADD;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
            out_zf_q    <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_res_q   <= out_res_d;
            out_zf_q    <= out_zf_d;
            out_err_q   <= out_err_d;
        end
    end

`ifdef BRANCH_RESOLVE_EN
    logic is_sub_q, is_sub_d;
    logic out_branch_q, out_branch_d;

    always_comb begin
        is_sub_d     = is_sub_q;
        out_branch_d = out_branch_q;
        if (accept)  is_sub_d = (alu_op == 2'b01);
        if (capture) out_branch_d = is_sub_q && alu_zf;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_sub_q     <= 1'b0;
            out_branch_q <= 1'b0;
        end else begin
            is_sub_q     <= is_sub_d;
            out_branch_q <= out_branch_d;
        end
    end

    assign out_branch = out_branch_q;
`else
    assign out_branch = 1'b0;
`endif

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign out_valid = out_valid_q;
    assign out_res   = out_res_q;
    assign out_zf    = out_zf_q;
    assign out_err   = out_err_q;

endmodule
